// File: rtl/mdu.sv
// mdu: iterative 32-bit multiply/divide unit driving the HI/LO register pair
module mdu #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state;
    logic [4:0] cnt;
    logic [63:0] p, prod;
    logic [31:0] b, a0, am, bm, q, r;
    logic [32:0] sum, diff;
    logic isdiv, qs, rs, sg, mdop;
    always_comb begin
        sg = MDUOp == 3'd1 || MDUOp == 3'd3;
        mdop = MDUOp >= 3'd1 && MDUOp <= 3'd4;
        am = sg && A[31] ? -A : A;
        bm = sg && B[31] ? -B : B;
        sum = {1'b0, p[63:32]} + {1'b0, b};
        diff = p[63:31] - {1'b0, b};
        prod = qs ? -p : p;
        q = qs ? -p[31:0] : p[31:0];
        r = rs ? -p[63:32] : p[63:32];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            HI <= '0;
            LO <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            cnt <= '0;
            p <= '0;
            b <= '0;
            a0 <= '0;
            isdiv <= 1'b0;
            qs <= 1'b0;
            rs <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (mdop) begin
                        state <= CALC;
                        busy <= 1'b1;
                        cnt <= '0;
                        p <= {32'd0, am};
                        b <= bm;
                        a0 <= A;
                        isdiv <= MDUOp == 3'd3 || MDUOp == 3'd4;
                        qs <= sg & (A[31] ^ B[31]);
                        rs <= sg & A[31];
                    end else if (MDUOp == 3'd5) HI <= A;
                    else if (MDUOp == 3'd6) LO <= A;
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (isdiv) p <= diff[32] ? {p[62:0], 1'b0} : {diff[31:0], p[30:0], 1'b1};
                    else p <= {p[0] ? sum : {1'b0, p[63:32]}, p[31:1]};
                    if (cnt == 5'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (isdiv) begin
                        HI <= b == '0 ? a0 : r;
                        LO <= b == '0 ? '1 : q;
                    end else {HI, LO} <= prod;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and randomized scoreboard bench for mdu
module tb_mdu;
    logic clk = 0, rst_n = 0, start = 0;
    logic [2:0] MDUOp = 0;
    logic [31:0] A = 0, B = 0;
    logic busy, done;
    logic [31:0] HI, LO;
    int total = 0, bad = 0;
    typedef struct {logic [31:0] hi; logic [31:0] lo;} exp_t;
    exp_t sbq[$];

    mdu #(.ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op;
        A = a;
        B = b;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_result(input string tag, input int nbusy);
        int bc = 0, k = 0;
        exp_t e;
        while (done !== 1'b1 && k < 80) begin
            if (busy) bc++;
            @(negedge clk);
            k++;
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busycycles"}, bc, nbusy);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, ".HI"}, HI, e.hi);
            chk({tag, ".LO"}, LO, e.lo);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        push(hi, lo);
        drive(op, a, b);
        wait_result(tag, 33);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        longint sp;
        longint unsigned up;
        int sa, sb;
        repeat (3) @(negedge clk);
        chk("reset.HI", HI, 0);
        chk("reset.LO", LO, 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.done", 32'(done), 0);
        rst_n = 1;
        @(negedge clk);

        run("mult_neg3x5", 3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run("div_neg7by2", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run("divu_100by7", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
        run("divu_by0", 3'd4, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        run("div_by0", 3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        push(32'd0, 32'd42);
        drive(3'd1, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        MDUOp = 3'd5;
        A = 32'hDEAD;
        start = 1;
        @(negedge clk);
        MDUOp = 3'd3;
        A = 32'd9;
        B = 32'd2;
        @(negedge clk);
        start = 0;
        wait_result("interlock", 22);

        @(negedge clk);
        drive(3'd6, 32'h1234, 32'd0);
        chk("mtlo.LO", LO, 32'h1234);
        chk("mtlo.busy", 32'(busy), 0);
        chk("mtlo.done", 32'(done), 0);

        push(32'd0, 32'd6);
        push(32'd0, 32'd6);
        MDUOp = 3'd1;
        A = 32'd2;
        B = 32'd3;
        start = 1;
        @(negedge clk);
        wait_result("b2b_first", 33);
        @(negedge clk);
        chk("b2b.restart_busy", 32'(busy), 1);
        chk("b2b.restart_done", 32'(done), 0);
        start = 0;
        wait_result("b2b_second", 33);
        @(negedge clk);

        drive(3'd5, 32'h55, 32'd0);
        chk("mthi.HI", HI, 32'h55);
        drive(3'd6, 32'h55, 32'd0);
        chk("mtlo55.LO", LO, 32'h55);
        drive(3'd4, 32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        chk("abort.HI", HI, 0);
        chk("abort.LO", LO, 0);
        rst_n = 1;
        @(negedge clk);
        run("multu_3x4", 3'd2, 32'd3, 32'd4, 32'd0, 32'd12);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            sp = longint'($signed(ra)) * longint'($signed(rb));
            run("rnd_mult", 3'd1, ra, rb, sp[63:32], sp[31:0]);
            up = {32'd0, ra} * {32'd0, rb};
            run("rnd_multu", 3'd2, ra, rb, up[63:32], up[31:0]);
            rb = $urandom_range(1, 32'hFFFF);
            run("rnd_divu", 3'd4, ra, rb, ra % rb, ra / rb);
            sa = $signed(ra);
            sb = $signed($urandom_range(1, 1000)) * ((i % 2) ? -1 : 1);
            run("rnd_div", 3'd3, sa, sb, sa % sb, sa / sb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
